// File: rtl/alu.sv
// alu: 8-bit ALU with basic, unary, compare and shift/bit-op classes; registered result and flags
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] alu_cmd,
  input  logic [1:0] Type,
  input  logic [2:0] M_op,
  input  logic [1:0] C_op,
  input  logic [2:0] A_op,
  input  logic       V_op,
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic       sc_i,
  output logic [7:0] rslt,
  output logic       sc_o,
  output logic       pari,
  output logic       zero
);
  logic [7:0] rslt_d, rslt_q;
  logic sc_d, sc_q, pari_d, pari_q, zero_d, zero_q;
  logic [8:0] add_w, sub_w;
  logic [15:0] shl_w, shr_w, sar_w;
  logic [7:0] rol_w, bit_m;
  logic [2:0] n;
  logic a_sc;
  assign n = inB[2:0];
  assign add_w = {1'b0, inA} + {1'b0, inB} + {8'b0, sc_i};
  assign sub_w = {1'b0, inA} - {1'b0, inB} - {8'b0, sc_i};
  assign shl_w = {8'b0, inA} << n;
  assign shr_w = {inA, 8'b0} >> n;
  assign sar_w = $signed({inA, 8'b0}) >>> n;
  assign rol_w = (inA << n) | (inA >> (3'd0 - n));
  assign bit_m = 8'b1 << n;
  always_comb begin
    rslt_d = 8'h00;
    sc_d = 1'b0;
    a_sc = 1'b0;
    case (Type)
      2'b00:
        case (alu_cmd)
          3'b000: {sc_d, rslt_d} = add_w;
          3'b001: {sc_d, rslt_d} = sub_w;
          3'b010: rslt_d = inA & inB;
          3'b011: rslt_d = inA ^ inB;
          3'b100: rslt_d = inA | inB;
          3'b101: {sc_d, rslt_d} = {inA, sc_i};
          3'b110: {rslt_d, sc_d} = {sc_i, inA};
          default: rslt_d = inA;
        endcase
      2'b01:
        case (M_op)
          3'b000: {sc_d, rslt_d} = {inA == 8'hff, inA + 8'd1};
          3'b001: {sc_d, rslt_d} = {inA == 8'h00, inA - 8'd1};
          3'b010: rslt_d = ~inA;
          3'b011: rslt_d = 8'd0 - inA;
          3'b100: {sc_d, rslt_d} = {inA[7], inA[6:0], inA[7]};
          3'b101: {sc_d, rslt_d} = {inA[0], inA[0], inA[7:1]};
          3'b110: rslt_d = inB;
          default: rslt_d = 8'h00;
        endcase
      2'b10: begin
        sc_d = C_op == 2'b00 ? inA == inB :
               C_op == 2'b01 ? inA < inB :
               C_op == 2'b10 ? inA > inB : $signed(inA) < $signed(inB);
        rslt_d = {7'b0, sc_d};
      end
      default: begin
        case (A_op)
          3'b000: {a_sc, rslt_d} = {|shl_w[15:8], shl_w[7:0]};
          3'b001: {a_sc, rslt_d} = {|shr_w[7:0], shr_w[15:8]};
          3'b010: {a_sc, rslt_d} = {|sar_w[7:0], sar_w[15:8]};
          3'b011: rslt_d = rol_w;
          3'b100: {a_sc, rslt_d} = {inA[n], inA | bit_m};
          3'b101: {a_sc, rslt_d} = {inA[n], inA & ~bit_m};
          3'b110: {a_sc, rslt_d} = {inA[n], 7'b0, inA[n]};
          default: rslt_d = {inA[3:0], inA[7:4]};
        endcase
        sc_d = V_op & a_sc;
      end
    endcase
    pari_d = ^rslt_d;
    zero_d = rslt_d == 8'h00;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rslt_q <= 8'h00;
      sc_q <= 1'b0;
      pari_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      rslt_q <= rslt_d;
      sc_q <= sc_d;
      pari_q <= pari_d;
      zero_q <= zero_d;
    end
  end
  assign rslt = rslt_q;
  assign sc_o = sc_q;
  assign pari = pari_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors with hand-computed results, checked by a queue-based scoreboard monitor
module tb_alu;
  logic clk = 1'b0, reset = 1'b0, V_op = 1'b0, sc_i = 1'b0;
  logic [2:0] alu_cmd = '0, M_op = '0, A_op = '0;
  logic [1:0] Type = '0, C_op = '0;
  logic [7:0] inA = '0, inB = '0, rslt;
  logic sc_o, pari, zero;
  typedef struct {logic [7:0] r; logic c, p, z; string nm;} exp_t;
  exp_t q[$];
  int checks = 0, passed = 0;
  alu dut (.clk(clk), .reset(reset), .alu_cmd(alu_cmd), .Type(Type), .M_op(M_op), .C_op(C_op),
           .A_op(A_op), .V_op(V_op), .inA(inA), .inB(inB), .sc_i(sc_i), .rslt(rslt), .sc_o(sc_o),
           .pari(pari), .zero(zero));
  always #5 clk = ~clk;
  task automatic op(input logic rst_v, input logic [1:0] t, input logic [2:0] s, input logic v,
                    input logic [7:0] a, input logic [7:0] b, input logic si,
                    input logic [7:0] r, input logic c, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst_v; Type = t; V_op = v; inA = a; inB = b; sc_i = si;
    alu_cmd = t == 2'b00 ? s : ~s;
    M_op = t == 2'b01 ? s : ~s;
    C_op = t == 2'b10 ? s[1:0] : ~s[1:0];
    A_op = t == 2'b11 ? s : ~s;
    e.r = r; e.c = c; e.p = ^r; e.z = r == 8'h00; e.nm = nm;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 4;
      if (rslt === e.r) passed++; else $display("FAIL %s rslt got %h want %h", e.nm, rslt, e.r);
      if (sc_o === e.c) passed++; else $display("FAIL %s sc_o got %b want %b", e.nm, sc_o, e.c);
      if (pari === e.p) passed++; else $display("FAIL %s pari got %b want %b", e.nm, pari, e.p);
      if (zero === e.z) passed++; else $display("FAIL %s zero got %b want %b", e.nm, zero, e.z);
    end
  end
  initial begin
    op(1, 2'b00, 3'b000, 0, 8'h12, 8'h34, 1, 8'h00, 0, "reset1");
    op(1, 2'b01, 3'b010, 1, 8'h12, 8'h34, 1, 8'h00, 0, "reset2");
    op(0, 2'b00, 3'b000, 0, 8'h01, 8'h01, 1, 8'h03, 0, "add_ci");
    op(0, 2'b00, 3'b011, 0, 8'hAA, 8'h55, 1, 8'hFF, 0, "xor");
    op(0, 2'b00, 3'b010, 0, 8'hAA, 8'h55, 1, 8'h00, 0, "and");
    op(0, 2'b00, 3'b001, 0, 8'h01, 8'h01, 1, 8'hFF, 1, "sub_borrow");
    op(0, 2'b00, 3'b000, 0, 8'hFF, 8'h01, 0, 8'h00, 1, "add_wrap");
    op(0, 2'b00, 3'b100, 0, 8'hF0, 8'h0F, 1, 8'hFF, 0, "or");
    op(0, 2'b00, 3'b101, 0, 8'h81, 8'h00, 0, 8'h02, 1, "shl_ci");
    op(0, 2'b00, 3'b110, 0, 8'h81, 8'h00, 1, 8'hC0, 1, "shr_ci");
    op(0, 2'b00, 3'b111, 0, 8'h5A, 8'hFF, 1, 8'h5A, 0, "pass_a");
    op(0, 2'b01, 3'b000, 0, 8'hFF, 8'h00, 1, 8'h00, 1, "inc_wrap");
    op(0, 2'b01, 3'b001, 0, 8'h00, 8'h00, 1, 8'hFF, 1, "dec_wrap");
    op(0, 2'b01, 3'b010, 0, 8'h0F, 8'h00, 1, 8'hF0, 0, "not");
    op(0, 2'b01, 3'b011, 0, 8'h01, 8'h00, 1, 8'hFF, 0, "neg");
    op(0, 2'b01, 3'b100, 0, 8'h81, 8'h00, 0, 8'h03, 1, "rol1");
    op(0, 2'b01, 3'b101, 0, 8'h81, 8'h00, 0, 8'hC0, 1, "ror1");
    op(0, 2'b01, 3'b110, 0, 8'h11, 8'h3C, 1, 8'h3C, 0, "pass_b");
    op(0, 2'b01, 3'b111, 0, 8'h11, 8'h3C, 1, 8'h00, 0, "clear");
    op(0, 2'b10, 3'b011, 0, 8'h80, 8'h01, 1, 8'h01, 1, "lt_signed");
    op(0, 2'b10, 3'b001, 0, 8'h80, 8'h01, 1, 8'h00, 0, "lt_unsigned");
    op(0, 2'b10, 3'b000, 0, 8'h42, 8'h42, 0, 8'h01, 1, "eq");
    op(0, 2'b10, 3'b010, 0, 8'h80, 8'h01, 0, 8'h01, 1, "gt_unsigned");
    op(0, 2'b11, 3'b001, 1, 8'h03, 8'h01, 0, 8'h01, 1, "lsr_v");
    op(1, 2'b11, 3'b001, 1, 8'h03, 8'h01, 0, 8'h00, 0, "reset_override");
    op(0, 2'b11, 3'b000, 1, 8'hC1, 8'h02, 1, 8'h04, 1, "lsl2");
    op(0, 2'b11, 3'b000, 1, 8'hC1, 8'h00, 1, 8'hC1, 0, "lsl0");
    op(0, 2'b11, 3'b010, 1, 8'h84, 8'h02, 1, 8'hE1, 0, "asr2");
    op(0, 2'b11, 3'b010, 1, 8'h83, 8'h01, 0, 8'hC1, 1, "asr1");
    op(0, 2'b11, 3'b011, 1, 8'h81, 8'hF4, 1, 8'h18, 0, "rotl4");
    op(0, 2'b11, 3'b100, 1, 8'h10, 8'h04, 0, 8'h10, 1, "bset");
    op(0, 2'b11, 3'b101, 1, 8'h10, 8'h04, 0, 8'h00, 1, "bclr");
    op(0, 2'b11, 3'b110, 1, 8'hA5, 8'h02, 0, 8'h01, 1, "btst");
    op(0, 2'b11, 3'b111, 1, 8'hA5, 8'h00, 1, 8'h5A, 0, "swap");
    op(0, 2'b11, 3'b000, 0, 8'hC1, 8'h02, 1, 8'h04, 0, "lsl2_novop");
    op(0, 2'b11, 3'b001, 1, 8'hF0, 8'h03, 1, 8'h1E, 0, "lsr3");
    op(0, 2'b11, 3'b110, 0, 8'hA5, 8'h02, 0, 8'h01, 0, "btst_novop");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain pending %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 alu_cmd  input  3  basic operation select, used when Type=00.
REQ-005 Type  input  2  class select: 00 basic, 01 M_op, 10 C_op, 11 A_op.
REQ-006 M_op  input  3  unary-op select (Type=01).
REQ-007 C_op  input  2  compare select (Type=10).
REQ-008 A_op  input  3  shift/bit-op select (Type=11).
REQ-009 V_op  input  1  Type=11 only: 1 = sc_o reports shifted-out/tested bit; 0 = sc_o forced 0.
REQ-010 inA, inB  input  8 each  operands.
REQ-011 sc_i  input  1  carry/borrow/shift-in.
REQ-012 rslt  output  8  registered result.
REQ-013 sc_o  output  1  registered carry/borrow/shift-out.
REQ-014 pari  output  1  registered XOR-reduction of rslt (1 = odd count of ones).
REQ-015 zero  output  1  registered flag, 1 when rslt==8'h00.

Function
REQ-016 The result SHALL be computed combinationally and all four outputs SHALL register on the rising clk edge; latency exactly 1 cycle, new operation accepted every cycle, no handshake.
REQ-017 pari and zero SHALL be derived from the same next-state rslt, so flags always match the displayed rslt.
REQ-018 Type=00 by alu_cmd: 000 {sc_o,rslt}=inA+inB+sc_i; 001 rslt=inA-inB-sc_i, sc_o=1 on borrow; 010 AND; 011 XOR; 100 OR; 101 rslt={inA[6:0],sc_i}, sc_o=inA[7]; 110 rslt={sc_i,inA[7:1]}, sc_o=inA[0]; 111 rslt=inA. sc_o=0 for 010/011/100/111.
REQ-019 Type=01 by M_op: 000 inA+1, sc_o=1 iff inA=FF; 001 inA-1, sc_o=1 iff inA=00; 010 ~inA; 011 0-inA; 100 rotate left 1, sc_o=inA[7]; 101 rotate right 1, sc_o=inA[0]; 110 rslt=inB; 111 rslt=00. sc_o=0 unless stated.
REQ-020 Type=10 by C_op: 00 inA==inB; 01 inA<inB unsigned; 10 inA>inB unsigned; 11 inA<inB signed two's complement; rslt=8'h01 if true else 8'h00; sc_o=rslt[0].
REQ-021 Type=11 by A_op, n=inB[2:0]: 000 inA<<n; 001 inA>>n logical; 010 arithmetic >>n; 011 rotate left n; 100 inA|(1<<n); 101 inA&~(1<<n); 110 {7'b0,inA[n]}; 111 {inA[3:0],inA[7:4]}.
REQ-022 Type=11 with V_op=1: sc_o=OR of bits shifted out (000/001/010), 0 for 011/111, original inA[n] for 100/101/110; V_op=0 forces sc_o=0.
REQ-023 All arithmetic SHALL be 8-bit modulo 256; n=0 shifts SHALL pass inA unchanged with sc_o=0.
REQ-024 sc_i SHALL be ignored by every operation not listed as using it.

Reset
REQ-025 While reset is high at a rising clk edge: rslt=8'h00, sc_o=0, pari=0, zero=1; reset overrides any computation that cycle.
REQ-026 Output values SHALL hold between edges; the first operation after reset deasserts appears one cycle later.

Verification
REQ-027 Assert reset 2 cycles -> rslt=00, sc_o=0, pari=0, zero=1.
REQ-028 Type=00, alu_cmd=000, inA=01, inB=01, sc_i=1 -> next cycle rslt=03, sc_o=0, pari=0, zero=0.
REQ-029 alu_cmd=011, inA=AA, inB=55 -> rslt=FF, pari=0, zero=0; then alu_cmd=010 same operands -> rslt=00, zero=1.
REQ-030 alu_cmd=001, inA=01, inB=01, sc_i=1 -> rslt=FF, sc_o=1, pari=0.
REQ-031 Type=10, C_op=11, inA=80, inB=01 -> rslt=01, sc_o=1, pari=1; C_op=01 same operands -> rslt=00, zero=1.
REQ-032 Type=11, A_op=001, V_op=1, inA=03, inB=01 -> rslt=01, sc_o=1; reset asserted same cycle -> rslt=00, zero=1.
